// File: rtl/spi_result_tx_if.sv
// spi_result_tx_if: read port of the result BRAM as seen by the SPI transmitter.
// The master side (transmitter) issues the read enable and address and receives
// the read data one clock after the enable.
interface spi_result_tx_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) ();
  logic                  res_rd_en;
  logic [ADDR_WIDTH-1:0] res_rd_addr;
  logic [DATA_WIDTH-1:0] res_rd_data;

  modport master (output res_rd_en, output res_rd_addr, input res_rd_data);
  modport slave  (input res_rd_en, input res_rd_addr, output res_rd_data);
endinterface

// File: rtl/spi_result_tx.sv
// spi_result_tx: streams result BRAM words to an SPI master (mode 0, MSB first).
// sclk and cs_n are synchronised into clk; a frame starts on cs_n falling and
// aborts on cs_n rising. The word after the current one is prefetched into
// next_word_r so word boundaries never wait on the BRAM.
// Optional build macro TX_STATUS_HEADER_EN: each frame is preceded by a status
// header word {8'hA5, 7'b0, results_ready, NUM_WORDS[15:0]}.
module spi_result_tx #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            spi_sclk,
  input  logic            spi_cs_n,
  output logic            spi_miso,
  input  logic            results_valid,
  spi_result_tx_if.master res,
  output logic            results_ready,
  output logic            tx_busy,
  output logic            tx_done
);

`ifdef TX_STATUS_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int FRAME_WORDS = NUM_WORDS + HDR_WORDS;
  localparam int SLOT_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int CNT_W       = $clog2(DATA_WIDTH + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DATA_WIDTH);
  localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  // Slot following s within a frame, wrapping to the frame start.
  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    logic [SLOT_W-1:0] r;
    if (s == LAST_SLOT) r = SLOT_ZERO;
    else                r = s + SLOT_W'(1'b1);
    return r;
  endfunction

`ifdef TX_STATUS_HEADER_EN
  // Status header word carrying the current results_ready flag.
  function automatic logic [DATA_WIDTH-1:0] header_word(input logic ready);
    return DATA_WIDTH'({8'hA5, 7'b000_0000, ready, 16'(NUM_WORDS)});
  endfunction
`endif

  // Synchroniser / edge-detect registers
  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic cs_meta_r, cs_sync_r, cs_prev_r;
  logic sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

  // Control and datapath state
  state_t                state_r, state_nxt_s;
  logic [CNT_W-1:0]      bit_cnt_r;
  logic [SLOT_W-1:0]     slot_r;
  logic [DATA_WIDTH-1:0] shift_r, next_word_r, load_word_s;
  logic                  miso_r, rd_en_r, pf_read_r, pf_cap_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic                  ready_r, busy_r, done_r;

  // Control strobes from the next-state logic
  logic                  abort_s, fetch_s, load_s, bit_inc_s, shift_s, adv_s;
  logic                  done_s, prefetch_s;
  logic [SLOT_W-1:0]     pf_slot_s;

  assign sclk_rise_s = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_sync_r & sclk_prev_r;
  assign cs_fall_s   = ~cs_sync_r & cs_prev_r;
  assign cs_rise_s   = cs_sync_r & ~cs_prev_r;

`ifdef TX_STATUS_HEADER_EN
  assign load_word_s = header_word(ready_r);
`else
  assign load_word_s = res.res_rd_data;
`endif

  // Two-flop synchronisers plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_meta_r <= spi_sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      cs_meta_r   <= spi_cs_n;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_nxt_s;
  end

  // Next-state logic and per-cycle control strobes; cs_n rising overrides all.
  always_comb begin
    state_nxt_s = state_r;
    abort_s     = 1'b0;
    fetch_s     = 1'b0;
    load_s      = 1'b0;
    bit_inc_s   = 1'b0;
    shift_s     = 1'b0;
    adv_s       = 1'b0;
    done_s      = 1'b0;
    prefetch_s  = 1'b0;
    pf_slot_s   = SLOT_ZERO;
    if (cs_rise_s) begin
      state_nxt_s = IDLE;
      abort_s     = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            state_nxt_s = FETCH;
            fetch_s     = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        FETCH: state_nxt_s = LOAD;
        LOAD: begin
          state_nxt_s = SHIFT;
          load_s      = 1'b1;
          prefetch_s  = 1'b1;
          pf_slot_s   = next_slot(SLOT_ZERO);
        end
        SHIFT: begin
          if (sclk_rise_s) begin
            if (bit_cnt_r != CNT_FULL) begin
              bit_inc_s = 1'b1;
              if ((bit_cnt_r == CNT_LAST) && (slot_r == LAST_SLOT)) done_s = 1'b1;
              else                                                  done_s = 1'b0;
            end else begin
              bit_inc_s = 1'b0;
            end
          end else if (sclk_fall_s) begin
            if (bit_cnt_r == CNT_FULL) begin
              adv_s      = 1'b1;
              prefetch_s = 1'b1;
              pf_slot_s  = next_slot(next_slot(slot_r));
            end else if (bit_cnt_r != CNT_ZERO) begin
              shift_s = 1'b1;
            end else begin
              shift_s = 1'b0;
            end
          end else begin
            state_nxt_s = SHIFT;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Datapath: BRAM reads, prefetch capture, shift register, counters and status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt_r   <= CNT_ZERO;
      slot_r      <= SLOT_ZERO;
      shift_r     <= {DATA_WIDTH{1'b0}};
      next_word_r <= {DATA_WIDTH{1'b0}};
      miso_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= {ADDR_WIDTH{1'b0}};
      pf_read_r   <= 1'b0;
      pf_cap_r    <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      rd_en_r   <= 1'b0;
      pf_read_r <= 1'b0;
      pf_cap_r  <= pf_read_r;
      done_r    <= done_s;
      busy_r    <= (state_nxt_s != IDLE);
      if (results_valid) ready_r <= 1'b1;
      else if (done_s)   ready_r <= 1'b0;
      if (pf_cap_r) next_word_r <= res.res_rd_data;

      if (abort_s) begin
        bit_cnt_r   <= CNT_ZERO;
        slot_r      <= SLOT_ZERO;
        shift_r     <= {DATA_WIDTH{1'b0}};
        next_word_r <= {DATA_WIDTH{1'b0}};
        miso_r      <= 1'b0;
        rd_addr_r   <= {ADDR_WIDTH{1'b0}};
        pf_cap_r    <= 1'b0;
      end else begin
        if (fetch_s) begin
          bit_cnt_r <= CNT_ZERO;
          slot_r    <= SLOT_ZERO;
`ifndef TX_STATUS_HEADER_EN
          rd_en_r   <= 1'b1;
          rd_addr_r <= {ADDR_WIDTH{1'b0}};
`endif
        end
        if (load_s) begin
          shift_r   <= load_word_s;
          miso_r    <= load_word_s[DATA_WIDTH-1];
          bit_cnt_r <= CNT_ZERO;
          slot_r    <= SLOT_ZERO;
        end
        if (bit_inc_s) bit_cnt_r <= bit_cnt_r + CNT_W'(1'b1);
        if (shift_s) begin
          shift_r <= {shift_r[DATA_WIDTH-2:0], 1'b0};
          miso_r  <= shift_r[DATA_WIDTH-2];
        end
        if (adv_s) begin
          shift_r   <= next_word_r;
          miso_r    <= next_word_r[DATA_WIDTH-1];
          bit_cnt_r <= CNT_ZERO;
          slot_r    <= next_slot(slot_r);
        end
        if (prefetch_s) begin
`ifdef TX_STATUS_HEADER_EN
          if (pf_slot_s == SLOT_ZERO) begin
            next_word_r <= header_word(ready_r);
          end else begin
            rd_en_r   <= 1'b1;
            rd_addr_r <= ADDR_WIDTH'(pf_slot_s - SLOT_W'(1'b1));
            pf_read_r <= 1'b1;
          end
`else
          rd_en_r   <= 1'b1;
          rd_addr_r <= ADDR_WIDTH'(pf_slot_s);
          pf_read_r <= 1'b1;
`endif
        end
      end
    end
  end

  assign spi_miso        = miso_r;
  assign res.res_rd_en   = rd_en_r;
  assign res.res_rd_addr = rd_addr_r;
  assign results_ready   = ready_r;
  assign tx_busy         = busy_r;
  assign tx_done         = done_r;

endmodule

// File: tb/tb_spi_result_tx.sv
// tb_spi_result_tx: acts as the SPI master (mode 0) and the result BRAM.
// Expected words come from a frame model: word k of a transfer is
// slot (k mod frame length) of {optional header, BRAM[0..NUM_WORDS-1]}.
module tb_spi_result_tx;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NW = 8;
`ifdef TX_STATUS_HEADER_EN
  localparam int FRAME = NW + 1;
`else
  localparam int FRAME = NW;
`endif

  logic clk = 1'b0;
  logic rst, spi_sclk, spi_cs_n, spi_miso, results_valid;
  logic results_ready, tx_busy, tx_done;

  spi_result_tx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  spi_result_tx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_sclk      (spi_sclk),
    .spi_cs_n      (spi_cs_n),
    .spi_miso      (spi_miso),
    .results_valid (results_valid),
    .res           (bus.master),
    .results_ready (results_ready),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Result BRAM: synchronous read, data one clock after enable.
  always @(posedge clk) begin
    if (bus.res_rd_en) bus.res_rd_data <= mem[bus.res_rd_addr];
  end

  int done_cnt = 0;
  // Count clocks during which tx_done is high.
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  int            checks = 0;
  int            errors = 0;
  int            half = 5;
  logic          exp_ready = 1'b0;
  logic [DW-1:0] rx_word;
  int            rx_cnt;
  logic [DW-1:0] rx_q [$];
  logic [DW-1:0] exp_q [$];
  logic          done_at_valid;

  function automatic logic [DW-1:0] model_word(input int k);
    int slot;
    slot = k % FRAME;
`ifdef TX_STATUS_HEADER_EN
    if (slot == 0) return {8'hA5, 7'd0, exp_ready, 16'(NW)};
    return mem[slot-1];
`else
    return mem[slot];
`endif
  endfunction

  task automatic build_expect(input int nwords);
    exp_q.delete();
    for (int k = 0; k < nwords; k++) exp_q.push_back(model_word(k));
  endtask

  task automatic fill_random();
    for (int i = 0; i < NW; i++) mem[i] = $urandom;
    half = $urandom_range(7, 4);
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_cnt  = 0;
    rx_word = '0;
  endtask

  task automatic pulse_valid();
    @(negedge clk) results_valid = 1'b1;
    @(negedge clk) results_valid = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic cs_start();
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_stop();
    @(negedge clk) spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Clock n bits; sample spi_miso as the sclk rising edge is driven.
  task automatic spi_bits(input int n, input bit valid_on_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      spi_sclk = 1'b1;
      rx_word  = {rx_word[DW-2:0], spi_miso};
      rx_cnt++;
      if (rx_cnt == DW) begin
        rx_q.push_back(rx_word);
        rx_cnt = 0;
      end
      for (int j = 1; j <= half; j++) begin
        @(negedge clk);
        if (valid_on_last && i == n - 1) begin
          if (j == 2) results_valid = 1'b1;
          if (j == 3) begin
            results_valid = 1'b0;
            done_at_valid = tx_done;
          end
        end
      end
      spi_sclk = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; results_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    checks++; if (results_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", results_ready); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", tx_done); end
    checks++; if (bus.res_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.res_rd_en); end
    checks++; if (bus.res_rd_addr !== 10'd0) begin errors++; $display("FAIL reset_rd_addr: got %h want 0", bus.res_rd_addr); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", tx_busy); end
  endtask

  task automatic test_known_frame();
    int base;
    for (int i = 0; i < NW; i++) mem[i] = 32'(i + 1);
    half = 5;
    pulse_valid();
    checks++; if (results_ready !== exp_ready) begin errors++; $display("FAIL ready_set: got %b want %b", results_ready, exp_ready); end
    build_expect(FRAME);
    base = done_cnt;
    rx_clear();
    cs_start();
    checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL frame_busy: got %b want 1", tx_busy); end
    spi_bits(FRAME * DW, 1'b0);
    repeat (3) @(negedge clk);
    exp_ready = 1'b0;
    checks++; if (rx_q.size() != FRAME) begin errors++; $display("FAIL known_count: got %0d want %0d", rx_q.size(), FRAME); end
    for (int i = 0; i < FRAME && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL known_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL known_done: got %0d want 1", done_cnt - base); end
    checks++; if (results_ready !== exp_ready) begin errors++; $display("FAIL known_ready: got %b want %b", results_ready, exp_ready); end
    cs_stop();
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", tx_busy); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL stop_miso: got %b want 0", spi_miso); end
    checks++; if (bus.res_rd_en !== 1'b0) begin errors++; $display("FAIL stop_rd_en: got %b want 0", bus.res_rd_en); end
  endtask

  task automatic test_abort();
    int base;
    logic [DW-1:0] first;
    fill_random();
    mem[0] = 32'hDEADBEEF;
    pulse_valid();
    first = model_word(0);
    base = done_cnt;
    rx_clear();
    cs_start();
    spi_bits(16, 1'b0);
    cs_stop();
    checks++; if (rx_word[15:0] !== first[31:16]) begin errors++; $display("FAIL abort_bits: got %h want %h", rx_word[15:0], first[31:16]); end
    checks++; if (done_cnt != base) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt - base); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", tx_busy); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL abort_miso: got %b want 0", spi_miso); end
    checks++; if (results_ready !== exp_ready) begin errors++; $display("FAIL abort_ready: got %b want %b", results_ready, exp_ready); end
    rx_clear();
    cs_start();
    spi_bits(DW, 1'b0);
    cs_stop();
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL restart_count: got %0d want 1", rx_q.size()); end
    else if (rx_q[0] !== first) begin errors++; $display("FAIL restart_word: got %h want %h", rx_q[0], first); end
  endtask

  task automatic test_back_to_back();
    int base;
    fill_random();
    pulse_valid();
    build_expect(2 * FRAME);
    base = done_cnt;
    rx_clear();
    cs_start();
    spi_bits(2 * FRAME * DW, 1'b0);
    repeat (3) @(negedge clk);
    exp_ready = 1'b0;
    checks++; if (rx_q.size() != 2 * FRAME) begin errors++; $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), 2 * FRAME); end
    for (int i = 0; i < 2 * FRAME && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt - base != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_cnt - base); end
    checks++; if (results_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready: got %b want %b", results_ready, exp_ready); end
    cs_stop();
  endtask

  task automatic test_valid_at_done();
    fill_random();
    build_expect(FRAME);
    done_at_valid = 1'b0;
    rx_clear();
    cs_start();
    spi_bits(FRAME * DW, 1'b1);
    exp_ready = 1'b1;
    checks++; if (done_at_valid !== 1'b1) begin errors++; $display("FAIL coincide_done: got %b want 1", done_at_valid); end
    checks++; if (results_ready !== exp_ready) begin errors++; $display("FAIL coincide_ready: got %b want %b", results_ready, exp_ready); end
    for (int i = 0; i < FRAME && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL coincide_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    cs_stop();
    checks++; if (results_ready !== exp_ready) begin errors++; $display("FAIL coincide_hold: got %b want %b", results_ready, exp_ready); end
  endtask

  task automatic test_reset_mid_frame();
    fill_random();
    rx_clear();
    cs_start();
    spi_bits(40, 1'b0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    exp_ready = 1'b0;
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b want 0", spi_miso); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
    checks++; if (results_ready !== exp_ready) begin errors++; $display("FAIL rstmid_ready: got %b want %b", results_ready, exp_ready); end
    spi_cs_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    build_expect(2);
    rx_clear();
    cs_start();
    spi_bits(2 * DW, 1'b0);
    cs_stop();
    checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL rstmid_count: got %0d want 2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_known_frame();
    test_abort();
    test_back_to_back();
    test_valid_at_done();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_result_tx.md
SPI_RESULT_TX -- requirements
Module: spi_result_tx

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, result BRAM address width.
REQ-002 Parameter DATA_WIDTH, default 32, result word width in bits.
REQ-003 Parameter NUM_WORDS, default 8, number of result words per frame.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-low (0 = reset).
REQ-006 spi_sclk  in  1  SPI clock from Raspberry Pi, asynchronous to clk.
REQ-007 spi_cs_n  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-008 spi_miso  out  1  serial result data to the Pi, MSB first.
REQ-009 results_valid  in  1  one-cycle pulse (matmul done) marking the result BRAM contents as fresh.
REQ-010 res_rd_en  out  1  result BRAM read enable.
REQ-011 res_rd_addr  out  ADDR_WIDTH  result BRAM read address.
REQ-012 res_rd_data  in  DATA_WIDTH  result BRAM read data, valid 1 clk after res_rd_en.
REQ-013 results_ready  out  1  fresh results not yet fully transmitted.
REQ-014 tx_busy  out  1  frame in progress (CS asserted and state not IDLE).
REQ-015 tx_done  out  1  one-cycle pulse when the last bit of word NUM_WORDS-1 has been sampled.

Function
REQ-016 spi_sclk and spi_cs_n SHALL pass through 2-FF synchronizers; rising/falling edges detected on synchronized values; clk SHALL be >= 8x sclk frequency.
REQ-017 SPI mode 0: Pi samples on sclk rising edge; block updates spi_miso only on synchronized sclk falling edges, except first bit of a frame.
REQ-018 State machine IDLE -> FETCH -> LOAD -> SHIFT; IDLE exits on synchronized cs_n falling edge.
REQ-019 FETCH: res_rd_en=1, res_rd_addr=0 for one cycle; LOAD: shift register <= res_rd_data, spi_miso <= bit DATA_WIDTH-1; then SHIFT.
REQ-020 Latency from raw spi_cs_n falling edge to spi_miso valid SHALL be <= 6 clk; Pi waits >= 6 clk before first sclk rising edge.
REQ-021 On entering SHIFT, block SHALL prefetch word index+1 (mod NUM_WORDS) into a next-word register; prefetch complete well before the word boundary.
REQ-022 Bit counter counts sampled (rising) edges 0..DATA_WIDTH-1; on the falling edge after the DATA_WIDTH-th rising edge, shift register <= next word, spi_miso <= its MSB, word index increments, next prefetch issued.
REQ-023 Word index wraps NUM_WORDS-1 -> 0; transmission continues if sclk continues (repeated frames).
REQ-024 tx_done SHALL pulse on the rising-edge sample of the last bit of word NUM_WORDS-1; results_ready cleared in the same cycle.
REQ-025 results_valid sets results_ready; if results_valid coincides with tx_done, results_ready SHALL remain 1.
REQ-026 cs_n deassertion (synchronized rising edge) in any state SHALL abort: state IDLE, counters 0, spi_miso 0, results_ready unchanged, no tx_done.
REQ-027 In IDLE and while cs_n high, spi_miso SHALL drive 0 and res_rd_en SHALL be 0.
REQ-028 sclk edges while in IDLE, FETCH or LOAD SHALL be ignored.

Reset
REQ-029 While rst=0 at a clk edge: state IDLE, spi_miso=0, res_rd_en=0, res_rd_addr=0, results_ready=0, tx_busy=0, tx_done=0, all counters and shift/prefetch registers 0, synchronizers to idle values (sclk 0, cs_n 1).
REQ-030 Reset asserted mid-frame SHALL take effect on the next clk edge regardless of SPI activity.

Configuration
REQ-031 Macro TX_STATUS_HEADER_EN: when defined, each frame SHALL be preceded by a header word {8'hA5, 7'b0, results_ready, NUM_WORDS[15:0]} (results_ready sampled at LOAD), no BRAM read for it, word 0 follows; frame = NUM_WORDS+1 words, wrap returns to header.
REQ-032 Without TX_STATUS_HEADER_EN, frame = NUM_WORDS data words starting at address 0; no header logic present.

Verification
REQ-033 BRAM[0..7]=0x00000001..0x00000008, results_valid pulse, CS low, 256 sclk -> Pi receives 0x00000001..0x00000008 MSB first, tx_done single pulse, results_ready 1->0.
REQ-034 BRAM[0]=0xDEADBEEF, CS low, 16 sclk, CS high -> Pi gets 0xDEAD, no tx_done, state IDLE, results_ready stays 1; next CS frame restarts at 0xDEADBEEF.
REQ-035 CS low, 512 sclk -> two full frames, identical data, tx_done pulses twice.
REQ-036 results_valid pulse in same cycle as tx_done -> results_ready=1 afterwards.
REQ-037 rst=0 asserted after 40 sclk -> next clk: spi_miso=0, tx_busy=0, results_ready=0; fresh CS frame begins at word 0.
REQ-038 TX_STATUS_HEADER_EN defined, results_ready=1, NUM_WORDS=8 -> first word 0xA5010008, then BRAM[0..7].
